// File: rtl/parity_stream_checker.sv
// parity_stream_checker
// Deserialises framed serial data (DATA_W data bits LSB-first followed by one
// parity bit), checks parity in odd or even mode latched at the first data
// bit, presents the word with an error flag and keeps a saturating error
// count. All outputs are registered.

// Protocol checker: properties that must hold on the registered outputs.
module parity_stream_checker_props #(
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             done,
  input logic             busy,
  input logic [CNT_W-1:0] err_count
);

  // A completed frame always leaves the receiver idle.
  property p_done_not_busy;
    @(posedge clk) disable iff (rst) done |-> !busy;
  endproperty
  a_done_not_busy: assert property (p_done_not_busy);

  // done never stays high for two consecutive cycles.
  property p_done_single;
    @(posedge clk) disable iff (rst) done |=> !done;
  endproperty
  a_done_single: assert property (p_done_single);

  // The error count only steps up by one or clears to zero.
  property p_count_step;
    @(posedge clk) disable iff (rst)
      (err_count != $past(err_count)) |->
        ((err_count == ($past(err_count) + CNT_W'(1))) || (err_count == {CNT_W{1'b0}}));
  endproperty
  a_count_step: assert property (p_count_step);

endmodule

module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              odd_mode,
  input  logic              frame_rst,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  // bit_cnt must hold 0..DATA_W inclusive.
  localparam int BC_W = $clog2(DATA_W + 1);

  localparam logic [BC_W-1:0]   BC_ZERO   = {BC_W{1'b0}};
  localparam logic [BC_W-1:0]   BC_ONE    = BC_W'(1);
  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // RX_DATA while bit_cnt < DATA_W, RX_PARITY once all data bits are in.
  typedef enum logic [0:0] {
    RX_DATA   = 1'b0,
    RX_PARITY = 1'b1
  } state_t;

  // Parity verdict: total ones over data and parity bit must be odd in odd
  // mode and even in even mode; returns 1 on violation.
  function automatic logic parity_error(input logic acc, input logic pbit, input logic odd);
    logic total;
    total = acc ^ pbit;
    return odd ? ~total : total;
  endfunction

  state_t            state_r,     state_s;
  logic [BC_W-1:0]   bit_cnt_r,   bit_cnt_s;
  logic [DATA_W-1:0] shift_r,     shift_s;
  logic              acc_r,       acc_s;
  logic              mode_r,      mode_s;
  logic [DATA_W-1:0] data_out_r,  data_out_s;
  logic              error_r,     error_s;
  logic              done_r,      done_s;
  logic [CNT_W-1:0]  err_count_r, err_count_s;
  logic              busy_r,      busy_s;
  logic              frame_end_s;

  // Next-state logic for the frame receiver and the word/flag outputs.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    acc_s       = acc_r;
    mode_s      = mode_r;
    data_out_s  = data_out_r;
    error_s     = error_r;
    done_s      = 1'b0;
    frame_end_s = 1'b0;

    if (frame_rst) begin
      // Abort wins over a bit offered in the same cycle; that bit is dropped.
      state_s   = RX_DATA;
      bit_cnt_s = BC_ZERO;
    end else if (in_valid) begin
      case (state_r)
        RX_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            shift_s[i] = (bit_cnt_r == BC_W'(i)) ? in_bit : shift_r[i];
          end
          if (bit_cnt_r == BC_ZERO) begin
            // First bit of a frame: start parity fresh and freeze the mode.
            acc_s  = in_bit;
            mode_s = odd_mode;
          end else begin
            acc_s  = acc_r ^ in_bit;
            mode_s = mode_r;
          end
          bit_cnt_s = bit_cnt_r + BC_ONE;
          if (bit_cnt_r == BC_LAST) begin
            state_s = RX_PARITY;
          end else begin
            state_s = RX_DATA;
          end
        end
        RX_PARITY: begin
          frame_end_s = 1'b1;
          data_out_s  = shift_r;
          error_s     = parity_error(acc_r, in_bit, mode_r);
          done_s      = 1'b1;
          bit_cnt_s   = BC_ZERO;
          state_s     = RX_DATA;
        end
        default: begin
          state_s   = RX_DATA;
          bit_cnt_s = BC_ZERO;
        end
      endcase
    end else begin
      // Idle gap: everything holds.
      state_s   = state_r;
      bit_cnt_s = bit_cnt_r;
    end
  end

  // Saturating error counter; a clear beats a simultaneous increment.
  always_comb begin
    err_count_s = err_count_r;
    if (clr_cnt) begin
      err_count_s = CNT_ZERO;
    end else if (frame_end_s && error_s && (err_count_r != CNT_MAX)) begin
      err_count_s = err_count_r + CNT_ONE;
    end else begin
      err_count_s = err_count_r;
    end
  end

  // busy reflects whether the next cycle starts mid-frame.
  always_comb begin
    busy_s = (bit_cnt_s != BC_ZERO);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RX_DATA;
      bit_cnt_r   <= BC_ZERO;
      shift_r     <= DATA_ZERO;
      acc_r       <= 1'b0;
      mode_r      <= 1'b0;
      data_out_r  <= DATA_ZERO;
      error_r     <= 1'b0;
      done_r      <= 1'b0;
      err_count_r <= CNT_ZERO;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      acc_r       <= acc_s;
      mode_r      <= mode_s;
      data_out_r  <= data_out_s;
      error_r     <= error_s;
      done_r      <= done_s;
      err_count_r <= err_count_s;
      busy_r      <= busy_s;
    end
  end

  assign data_out  = data_out_r;
  assign done      = done_r;
  assign error     = error_r;
  assign err_count = err_count_r;
  assign busy      = busy_r;

  parity_stream_checker_props #(
    .CNT_W (CNT_W)
  ) u_props (
    .clk       (clk),
    .rst       (rst),
    .done      (done_r),
    .busy      (busy_r),
    .err_count (err_count_r)
  );

endmodule

// File: tb/tb_parity_stream_checker.sv
// Self-checking bench for parity_stream_checker with DATA_W=4, CNT_W=2.
`timescale 1ns/1ps
module tb_parity_stream_checker;

  localparam int DW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_bit;
  logic          odd_mode;
  logic          frame_rst;
  logic          clr_cnt;
  logic [DW-1:0] data_out;
  logic          done;
  logic          error;
  logic [CW-1:0] err_count;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            done_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [CW-1:0] m_cnt = 2'd0;

  parity_stream_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .odd_mode  (odd_mode),
    .frame_rst (frame_rst),
    .clr_cnt   (clr_cnt),
    .data_out  (data_out),
    .done      (done),
    .error     (error),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pops one expected frame and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt = done_cnt + 1;
      done_cyc.push_back(cyc);
      total = total + 1;
      if (sb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_unexpected_done: got done=1 data=%b, required no done", data_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.data) begin
          bad = bad + 1;
          $display("FAIL sb_data: got %b required %b", data_out, e.data);
        end
        total = total + 1;
        if (error !== e.err) begin
          bad = bad + 1;
          $display("FAIL sb_error: got %b required %b (data %b)", error, e.err, e.data);
        end
        total = total + 1;
        if (err_count !== e.cnt) begin
          bad = bad + 1;
          $display("FAIL sb_err_count: got %0d required %0d (data %b)", err_count, e.cnt, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends a full frame; the expected result is pushed as the parity bit goes out.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic odd,
                            input int gap, input logic clr_at_p, input logic toggle);
    int   ones;
    logic err;
    ones = $countones({d, p});
    err  = odd ? ((ones % 2) == 0) : ((ones % 2) != 0);
    for (int i = 0; i < DW; i++) begin
      odd_mode = (i == 0) ? odd : (toggle ? ~odd : odd);
      in_valid = 1'b1;
      in_bit   = d[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      idle(gap);
    end
    if (clr_at_p) m_cnt = 2'd0;
    else if (err && (m_cnt != 2'd3)) m_cnt = m_cnt + 2'd1;
    sb.push_back('{data: d, err: err, cnt: m_cnt});
    clr_cnt  = clr_at_p;
    in_valid = 1'b1;
    in_bit   = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    total += 5;
    if (data_out !== 4'b0000) begin bad++; $display("FAIL reset_data_out: got %b required 0000", data_out); end
    if (done !== 1'b0)        begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    if (error !== 1'b0)       begin bad++; $display("FAIL reset_error: got %b required 0", error); end
    if (err_count !== 2'd0)   begin bad++; $display("FAIL reset_err_count: got %0d required 0", err_count); end
    if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst   = 1'b0;
    m_cnt = 2'd0;
    idle(1);
  endtask

  task automatic test_odd_basic();
    send_frame(4'b0101, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle(2);
    total += 2;
    if (err_count !== 2'd1) begin bad++; $display("FAIL odd_basic_count: got %0d required 1", err_count); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL odd_basic_busy: got %b required 0", busy); end
  endtask

  task automatic test_gaps_and_even();
    send_frame(4'b1001, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    idle(1);
    send_frame(4'b0111, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    total += 1;
    if (err_count !== 2'd1) begin bad++; $display("FAIL gaps_count: got %0d required 1", err_count); end
  endtask

  task automatic test_back_to_back();
    int n0;
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    m_cnt   = 2'd0;
    total += 1;
    if (err_count !== 2'd0) begin bad++; $display("FAIL clr_idle: got %0d required 0", err_count); end
    n0 = done_cyc.size();
    for (int k = 0; k < 5; k++) send_frame(4'b0000, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle(1);
    total += 1;
    if (done_cyc.size() != n0 + 5) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d required %0d", done_cyc.size() - n0, 5);
    end else begin
      for (int k = 1; k < 5; k++) begin
        total += 1;
        if (done_cyc[n0 + k] - done_cyc[n0 + k - 1] != 5) begin
          bad++;
          $display("FAIL b2b_period: got %0d required 5", done_cyc[n0 + k] - done_cyc[n0 + k - 1]);
        end
      end
    end
    send_frame(4'b0011, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    idle(2);
    total += 2;
    if (err_count !== 2'd0) begin bad++; $display("FAIL clr_with_frame_count: got %0d required 0", err_count); end
    if (error !== 1'b1)     begin bad++; $display("FAIL clr_with_frame_error: got %b required 1", error); end
  endtask

  task automatic test_frame_abort();
    int n0;
    odd_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      idle(1);
    end
    in_valid = 1'b0;
    total += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b required 1", busy); end
    frame_rst = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    idle(1);
    frame_rst = 1'b0;
    in_valid  = 1'b0;
    total += 1;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after: got %b required 0", busy); end
    n0 = done_cnt;
    send_frame(4'b1101, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle(3);
    total += 1;
    if (done_cnt != n0 + 1) begin bad++; $display("FAIL abort_done_count: got %0d required 1", done_cnt - n0); end
  endtask

  task automatic test_mode_latch();
    send_frame(4'b0111, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    idle(2);
    total += 1;
    if (error !== 1'b0) begin bad++; $display("FAIL mode_latch_error: got %b required 0", error); end
  endtask

  task automatic test_reset_mid_frame();
    odd_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      idle(1);
    end
    in_valid = 1'b0;
    total += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b required 1", busy); end
    rst = 1'b1;
    #2;
    total += 4;
    if (data_out !== 4'b0000) begin bad++; $display("FAIL midrst_data_out: got %b required 0000", data_out); end
    if (error !== 1'b0)       begin bad++; $display("FAIL midrst_error: got %b required 0", error); end
    if (err_count !== 2'd0)   begin bad++; $display("FAIL midrst_err_count: got %0d required 0", err_count); end
    if (busy !== 1'b0)        begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    idle(1);
    rst   = 1'b0;
    m_cnt = 2'd0;
    idle(1);
    send_frame(4'b1010, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    total += 1;
    if (err_count !== 2'd1) begin bad++; $display("FAIL midrst_after_count: got %0d required 1", err_count); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    odd_mode  = 1'b1;
    frame_rst = 1'b0;
    clr_cnt   = 1'b0;
    test_reset();
    test_odd_basic();
    test_gaps_and_even();
    test_back_to_back();
    test_frame_abort();
    test_mode_latch();
    test_reset_mid_frame();
    total += 1;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
